fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue. It replaces the single-PC fetch with a decoupled front end: a fetch PC register issues one request per cycle to a synchronous instruction memory and buffers returned words, tagged with PC and exception code, in a DEPTH-entry FIFO. The FIFO feeds decode through a valid/ready handshake. It sits between the PC-redirect sources (branch/jump, ERET, interrupt) and the D-stage register.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: a fetch PC issues one request per cycle to a
// synchronous instruction memory and buffers tagged responses in a DEPTH-entry FIFO for decode.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'h3000,
  parameter logic [31:0] PC_LO     = 32'h3000,
  parameter logic [31:0] PC_HI     = 32'h4ffc,
  parameter logic [31:0] EXC_VEC   = 32'h4180,
  parameter logic [4:0]  ADEL_CODE = 5'd4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  input  logic                       eret,
  input  logic [31:0]                epc,
  input  logic                       int_req,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic [4:0]                 exc_out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   q_instr [DEPTH];
  logic [31:0]   q_pc    [DEPTH];
  logic [4:0]    q_exc   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  // The pending slot covers both real memory requests and illegal-PC slots,
  // so a fault entry lands in the queue with the same one-cycle latency.
  logic          pend_valid;
  logic          pend_illegal;
  logic [31:0]   pend_pc;

  logic          flush;
  logic [31:0]   flush_pc;
  logic          pc_legal;
  logic          deq;
  logic          enq;
  logic          issue;
  logic [CW:0]   credit;

  always_comb begin
    flush    = int_req | eret | redirect;
    flush_pc = redirect_pc;
    if (int_req)
      flush_pc = EXC_VEC;
    else if (eret)
      flush_pc = epc;
  end

  assign pc_legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= PC_LO) && (fetch_pc <= PC_HI);
  assign out_valid = (count_q != '0);
  assign deq       = out_valid & out_ready;
  assign enq       = pend_valid & ~flush;

  // Counting the dequeue lets issue resume in the same cycle decode unstalls.
  assign credit    = {1'b0, count_q} + (CW + 1)'(pend_valid) - (CW + 1)'(deq);
  assign issue     = ~flush && (credit < DEPTH_W);

  assign imem_req  = issue & pc_legal & ~reset;
  assign imem_addr = fetch_pc;

  assign instr_out = out_valid ? q_instr[rd_ptr] : '0;
  assign pc_out    = out_valid ? q_pc[rd_ptr]    : '0;
  assign exc_out   = out_valid ? q_exc[rd_ptr]   : '0;
  assign count     = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc     <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count_q      <= '0;
      pend_valid   <= 1'b0;
      pend_illegal <= 1'b0;
      pend_pc      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
        q_exc[i]   <= '0;
      end
    end else if (flush) begin
      fetch_pc   <= flush_pc;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= issue;
      if (issue) begin
        fetch_pc     <= fetch_pc + 32'd4;
        pend_pc      <= fetch_pc;
        pend_illegal <= ~pc_legal;
      end
      if (enq) begin
        q_instr[wr_ptr] <= pend_illegal ? '0 : imem_rdata;
        q_pc[wr_ptr]    <= pend_pc;
        q_exc[wr_ptr]   <= pend_illegal ? ADEL_CODE : '0;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(enq) - CW'(deq);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: expected head entries are queued when a fetch stream is started
// and compared at each decode handshake. Memory words are the address XOR a constant.
module tb_fetch_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc;
  } entry_t;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        eret;
  logic [31:0] epc;
  logic        int_req;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [4:0]  exc_out;
  logic [2:0]  count;

  int     errors = 0;
  int     checks = 0;
  int     pops;
  int     n_req;
  bit     bad;
  entry_t exp;
  entry_t sb[$];

  fetch_queue dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .eret(eret), .epc(epc), .int_req(int_req), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .instr_out(instr_out), .pc_out(pc_out),
    .exc_out(exc_out), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hcafe_0000;
  endfunction

  always @(posedge clk)
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hdead_beef;

  function automatic entry_t expect_at(input logic [31:0] pc);
    entry_t e;
    e.pc = pc;
    if (pc[1:0] == 2'b00 && pc >= 32'h3000 && pc <= 32'h4ffc) begin
      e.instr = mem_word(pc);
      e.exc   = 5'd0;
    end else begin
      e.instr = 32'h0;
      e.exc   = 5'd4;
    end
    return e;
  endfunction

  task automatic push_stream(input logic [31:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++)
      sb.push_back(expect_at(start + 32'(4 * i)));
  endtask

  // Leaves the caller just after the negedge that releases reset (cycle 0).
  task automatic restart(input logic rdy);
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; eret = 1'b0; int_req = 1'b0;
    redirect_pc = '0; epc = '0; out_ready = rdy;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; redirect = 1'b0; eret = 1'b0; int_req = 1'b0;
    redirect_pc = '0; epc = '0; out_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, out_valid, count} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: req/valid/count=%b exp 00000", {imem_req, out_valid, count});
    end
    checks++;
    if ({imem_addr, instr_out, pc_out, exc_out} !== {32'h3000, 32'h0, 32'h0, 5'h0}) begin
      errors++; $display("FAIL reset_data: addr=%h instr=%h pc=%h exc=%h", imem_addr, instr_out, pc_out, exc_out);
    end
    @(negedge clk);
    reset = 1'b0;
    push_stream(32'h3000, 16);
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
      errors++; $display("FAIL first_req: req=%b addr=%h exp 1 3000", imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, imem_addr} !== {1'b0, 32'h3004}) begin
      errors++; $display("FAIL cycle1: valid=%b addr=%h exp 0 3004", out_valid, imem_addr);
    end
    for (int c = 2; c < 10; c++) begin
      @(negedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL stream_valid: cycle %0d valid=%b exp 1", c, out_valid);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL stream_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL stream_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    restart(1'b0);
    push_stream(32'h3000, 12);
    n_req = 0;
    #1;
    if (imem_req) n_req++;
    for (int c = 1; c < 10; c++) begin
      @(negedge clk); #1;
      if (imem_req) n_req++;
    end
    checks++;
    if (n_req !== 4) begin
      errors++; $display("FAIL stall_issues: got %0d exp 4", n_req);
    end
    checks++;
    if ({count, imem_req, imem_addr} !== {3'd4, 1'b0, 32'h3010}) begin
      errors++; $display("FAIL stall_hold: count=%0d req=%b addr=%h exp 4 0 3010", count, imem_req, imem_addr);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 32'h3010}) begin
      errors++; $display("FAIL stall_resume: req=%b addr=%h exp 1 3010", imem_req, imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin
        errors++; $display("FAIL drain_gap: step %0d valid=%b exp 1", i, out_valid);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL drain_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL drain_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_redirect();
    restart(1'b0);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL redir_setup: count=%0d exp 3", count);
    end
    redirect = 1'b1; redirect_pc = 32'h3100;
    push_stream(32'h3100, 8);
    @(negedge clk);
    redirect = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({count, out_valid, imem_req, imem_addr} !== {3'd0, 1'b0, 1'b1, 32'h3100}) begin
      errors++; $display("FAIL redir_flush: count=%0d valid=%b req=%b addr=%h exp 0 0 1 3100",
                         count, out_valid, imem_req, imem_addr);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_bubble: valid=%b exp 0", out_valid);
    end
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (out_valid && out_ready) begin
        checks++; pops++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL redir_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL redir_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
    end
    checks++;
    if (pops !== 6) begin
      errors++; $display("FAIL redir_count: got %0d heads exp 6", pops);
    end
  endtask

  task automatic test_priority();
    restart(1'b1);
    for (int c = 1; c <= 3; c++) @(negedge clk);
    int_req = 1'b1; eret = 1'b1; redirect = 1'b1;
    epc = 32'h3200; redirect_pc = 32'h3300;
    push_stream(32'h4180, 8);
    bad = 1'b0; pops = 0;
    @(negedge clk);
    int_req = 1'b0; eret = 1'b0; redirect = 1'b0;
    #1;
    checks++;
    if (imem_addr !== 32'h4180) begin
      errors++; $display("FAIL prio_target: addr=%h exp 4180", imem_addr);
    end
    for (int i = 0; i < 8; i++) begin
      if (imem_req && (imem_addr == 32'h3200 || imem_addr == 32'h3300)) bad = 1'b1;
      if (out_valid && out_ready) begin
        checks++; pops++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL prio_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL prio_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({bad, pops} !== {1'b0, 32'(6)}) begin
      errors++; $display("FAIL prio_path: lower-priority fetch=%b heads=%0d exp 0 6", bad, pops);
    end
  endtask

  task automatic test_boundary();
    restart(1'b1);
    redirect = 1'b1; redirect_pc = 32'h4ff8;
    push_stream(32'h4ff8, 6);
    bad = 1'b0; pops = 0;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (imem_req && imem_addr >= 32'h5000) bad = 1'b1;
      if (out_valid && out_ready) begin
        checks++; pops++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bound_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL bound_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({bad, pops} !== {1'b0, 32'(6)}) begin
      errors++; $display("FAIL bound_req: illegal req=%b heads=%0d exp 0 6", bad, pops);
    end
    redirect = 1'b1; redirect_pc = 32'h3002;
    push_stream(32'h3002, 5);
    bad = 1'b0; pops = 0;
    @(negedge clk);
    redirect = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) begin
      if (imem_req) bad = 1'b1;
      if (out_valid && out_ready) begin
        checks++; pops++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL misalign_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL misalign_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({bad, pops} !== {1'b0, 32'(5)}) begin
      errors++; $display("FAIL misalign_req: req seen=%b heads=%0d exp 0 5", bad, pops);
    end
  endtask

  task automatic test_reset_midop();
    restart(1'b0);
    for (int c = 1; c <= 4; c++) @(negedge clk);
    #1;
    checks++;
    if (count !== 3'd3) begin
      errors++; $display("FAIL midrst_setup: count=%0d exp 3", count);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, count, imem_req, imem_addr} !== {1'b0, 3'd0, 1'b0, 32'h3000}) begin
      errors++; $display("FAIL midrst_async: valid=%b count=%0d req=%b addr=%h exp 0 0 0 3000",
                         out_valid, count, imem_req, imem_addr);
    end
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    push_stream(32'h3000, 8);
    pops = 0;
    #1;
    checks++;
    if ({imem_req, imem_addr, count} !== {1'b1, 32'h3000, 3'd0}) begin
      errors++; $display("FAIL midrst_restart: req=%b addr=%h count=%0d exp 1 3000 0", imem_req, imem_addr, count);
    end
    for (int i = 0; i < 8; i++) begin
      if (out_valid && out_ready) begin
        checks++; pops++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL midrst_entry: extra head pc=%h", pc_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out, exc_out} !== exp) begin
            errors++; $display("FAIL midrst_entry: got pc=%h instr=%h exc=%h exp pc=%h instr=%h exc=%h",
                               pc_out, instr_out, exc_out, exp.pc, exp.instr, exp.exc);
          end
        end
      end
      @(negedge clk); #1;
    end
    checks++;
    if (pops !== 6) begin
      errors++; $display("FAIL midrst_count: got %0d heads exp 6", pops);
    end
  endtask

  initial begin
    reset = 1'b1; redirect = 1'b0; eret = 1'b0; int_req = 1'b0;
    redirect_pc = '0; epc = '0; out_ready = 1'b0;
    test_reset();
    test_stall();
    test_redirect();
    test_priority();
    test_boundary();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
